// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU_* : 4-bit E-stage operation codes (9..15 behave as MDU_NONE)
//   - mdu_state_t : scheduler state encoding (ST_IDLE, ST_BUSY)
//   - DEF_* : default latencies and counter width
//   - mdu_is_issue / mdu_is_div : opcode classification helpers
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic mdu_is_issue(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational HI/LO result generator.
// Ports:
//   op          in  4   operation code (only MULT/MULTU/DIV/DIVU produce results)
//   a, b        in  32  rs / rt operands
//   res_hi      out 32  HI result (product high word or remainder)
//   res_lo      out 32  LO result (product low word or quotient)
//   div_by_zero out 1   DIV/DIVU with b == 0; results are don't-care
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero;
  logic               s_ovf;
  logic signed [31:0] bs_safe;
  logic        [31:0] bu_safe;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  assign b_zero = (b == 32'd0);
  // INT_MIN / -1 overflows; dividing by +1 instead yields exactly the
  // required quotient INT_MIN and remainder 0.
  assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Divisors never reach the divider as zero, so simulation never traps.
  assign bs_safe = (b_zero || s_ovf) ? 32'sd1 : $signed(b);
  assign bu_safe = b_zero ? 32'd1 : b;

  assign quo_s = $signed(a) / bs_safe;
  assign rem_s = $signed(a) % bs_safe;
  assign quo_u = a / bu_safe;
  assign rem_u = a % bu_safe;

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        res_hi      = rem_s;
        res_lo      = quo_s;
        div_by_zero = b_zero;
      end
      MDU_DIVU: begin
        res_hi      = rem_u;
        res_lo      = quo_u;
        div_by_zero = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide scheduler owning HI/LO.
// Ports:
//   clk, reset    system clock (rising) / asynchronous active-high reset
//   E_mdu_op      E-stage op code (see mdu_pkg)
//   E_rs_data     forwarded rs operand (also MTHI/MTLO source)
//   E_rt_data     forwarded rt operand
//   D_is_mdu      D-stage instruction is an MDU op (1..8)
//   busy          multi-cycle operation in flight
//   stall_mdu     stall request to the hazard unit
//   E_mdu_out     HI for MFHI, LO for MFLO, else 0
//   hi, lo        architectural HI/LO
// Results are computed at issue and held in pending registers; the
// counter only models latency and commits them when it expires.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdu_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_is_mdu,
  output logic        busy,
  output logic        stall_mdu,
  output logic [31:0] E_mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      pend_hi_reg, pend_hi_next;
  logic [31:0]      pend_lo_reg, pend_lo_next;
  logic             dbz_reg, dbz_next;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_dbz;
  logic             issue_op;

  mdu_arith u_arith (
    .op          (E_mdu_op),
    .a           (E_rs_data),
    .b           (E_rt_data),
    .res_hi      (arith_hi),
    .res_lo      (arith_lo),
    .div_by_zero (arith_dbz)
  );

  assign issue_op = mdu_is_issue(E_mdu_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      dbz_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      dbz_reg     <= dbz_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    dbz_next     = dbz_reg;
    case (state_reg)
      ST_IDLE: begin
        if (issue_op) begin
          pend_hi_next = arith_hi;
          pend_lo_next = arith_lo;
          dbz_next     = arith_dbz;
          cnt_next     = mdu_is_div(E_mdu_op) ? DIV_LAT : MULT_LAT;
          state_next   = ST_BUSY;
        end else if (E_mdu_op == MDU_MTHI) begin
          hi_next = E_rs_data;
        end else if (E_mdu_op == MDU_MTLO) begin
          lo_next = E_rs_data;
        end
      end
      ST_BUSY: begin
        // Incoming ops are ignored here; the stall keeps them out in
        // normal operation.
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          if (!dbz_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state_reg == ST_BUSY);
  assign stall_mdu = D_is_mdu && (busy || issue_op);
  assign hi        = hi_reg;
  assign lo        = lo_reg;

  always_comb begin
    E_mdu_out = 32'd0;
    if (E_mdu_op == MDU_MFHI) begin
      E_mdu_out = hi_reg;
    end else if (E_mdu_op == MDU_MFLO) begin
      E_mdu_out = lo_reg;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. The driver advances a
// cycle-level reference model (HI/LO values plus "cycles left busy")
// and queues the outputs expected during each cycle; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_is_mdu;
  logic        busy;
  logic        stall_mdu;
  logic [31:0] E_mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_mdu_op  (E_mdu_op),
    .E_rs_data (E_rs_data),
    .E_rt_data (E_rt_data),
    .D_is_mdu  (D_is_mdu),
    .busy      (busy),
    .stall_mdu (stall_mdu),
    .E_mdu_out (E_mdu_out),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        stall;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t cyc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  bit          m_pok;
  int          m_left;
  bit          p_r;
  logic [3:0]  p_op;
  logic [31:0] p_rs, p_rt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Architectural results from plain arithmetic; ok=0 means no commit.
  task automatic model_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rh, output logic [31:0] rl, output bit ok);
    longint      sa, sb, ma, mb, q, r, p;
    logic [63:0] pu;
    logic [63:0] qv, rv;
    rh = 32'd0; rl = 32'd0; ok = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin
        p = sa * sb; pu = p;
        rh = pu[63:32]; rl = pu[31:0];
      end
      4'd2: begin
        pu = 64'(a) * 64'(b);
        rh = pu[63:32]; rl = pu[31:0];
      end
      4'd3: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb;
          r = ma - q * mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          qv = q; rv = r;
          rl = qv[31:0]; rh = rv[31:0];
        end
      end
      default: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_pok = 0; m_left = 0;
  endtask

  // Effect of one rising edge given the inputs held during the previous cycle.
  task automatic model_edge();
    if (p_r) model_reset();
    else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin
        m_hi = m_ph; m_lo = m_pl;
      end
    end else if (p_op >= 4'd1 && p_op <= 4'd4) begin
      model_arith((p_op <= 4'd2) ? p_op : ((p_op == 4'd3) ? 4'd3 : 4'd4), p_rs, p_rt, m_ph, m_pl, m_pok);
      m_left = (p_op <= 4'd2) ? MC : DC;
    end else if (p_op == 4'd5) m_hi = p_rs;
    else if (p_op == 4'd6) m_lo = p_rs;
  endtask

  task automatic cyc(input bit r, input logic [3:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input bit dm);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    reset = r; E_mdu_op = op; E_rs_data = rs; E_rt_data = rt; D_is_mdu = dm;
    if (r) model_reset();
    e.busy  = (m_left > 0);
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.stall = dm && ((m_left > 0) || (op >= 4'd1 && op <= 4'd4));
    e.out   = (op == 4'd7) ? m_hi : ((op == 4'd8) ? m_lo : 32'd0);
    cyc_q.push_back(e);
    if (!r && m_left == 0 && op >= 4'd1 && op <= 4'd8)
      $display("op=%0d rs=%h rt=%h hi=%h lo=%h t=%0t", op, rs, rt, m_hi, m_lo, $time);
    p_r = r; p_op = op; p_rs = rs; p_rt = rt;
  endtask

  task automatic idle(input int n, input bit dm);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, dm);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      chk("busy",      {31'd0, busy},      {31'd0, mon_e.busy});
      chk("stall_mdu", {31'd0, stall_mdu}, {31'd0, mon_e.stall});
      chk("E_mdu_out", E_mdu_out,          mon_e.out);
      chk("hi",        hi,                 mon_e.hi);
      chk("lo",        lo,                 mon_e.lo);
    end
  end

  initial begin
    reset = 1'b1; E_mdu_op = 0; E_rs_data = 0; E_rt_data = 0; D_is_mdu = 0;
    model_reset();
    p_r = 1'b1; p_op = 0; p_rs = 0; p_rt = 0;

    cyc(1'b1, 4'd0, 0, 0, 0);
    cyc(1'b1, 4'd0, 0, 0, 0);
    idle(1, 0);

    // MULT -2*3 with an MFLO waiting in D, then read back
    cyc(0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1);
    idle(MC, 1);
    cyc(0, 4'd8, 0, 0, 1);
    cyc(0, 4'd7, 0, 0, 0);
    // MULTU same operands
    cyc(0, 4'd2, 32'hFFFF_FFFE, 32'd3, 0);
    idle(MC, 0);
    cyc(0, 4'd7, 0, 0, 0);
    // DIV -7/2 and DIVU 7/2
    cyc(0, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    idle(DC, 0);
    cyc(0, 4'd8, 0, 0, 0);
    cyc(0, 4'd4, 32'd7, 32'd2, 0);
    idle(DC, 0);
    // MTHI then MFHI; divide by zero leaves HI/LO alone
    cyc(0, 4'd5, 32'h1234_5678, 0, 1);
    cyc(0, 4'd7, 0, 0, 0);
    cyc(0, 4'd3, 32'd99, 32'd0, 0);
    idle(DC + 1, 0);
    // Reset in the third busy cycle of a DIV
    cyc(0, 4'd3, 32'd100, 32'd7, 0);
    idle(2, 0);
    cyc(1, 4'd0, 0, 0, 0);
    idle(DC + 2, 0);
    // INT_MIN / -1, with a MULT presented while busy
    cyc(0, 4'd6, 32'hCAFE_F00D, 0, 0);
    cyc(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(2, 0);
    cyc(0, 4'd1, 32'd1234, 32'd5678, 1);
    idle(DC, 0);
    cyc(0, 4'd8, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 199) == 0), 4'($urandom_range(0, 15)),
          rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
    end
    idle(DC + 2, 0);

    for (int i = 0; i < 10 && cyc_q.size() > 0; i++) @(negedge clk);
    #1;
    if (cyc_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", cyc_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
